// File: rtl/score_pkg.sv
// Shared definitions for the binary-to-BCD score display path.
package score_pkg;

    localparam int BCD_W = 4;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_SHIFT  = 2'd1;
    localparam state_t S_COMMIT = 2'd2;

    // Decimal digits needed to hold the largest BIN_W-bit value.
    function automatic int dec_digits(input int bits);
        longint v;
        int     n;
        v = (longint'(1) << bits) - 1;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    // Largest value representable in n decimal digits (10^n - 1).
    function automatic longint digit_limit(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r - 1;
    endfunction

endpackage

// File: rtl/score_digits_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
    import score_pkg::*;
(
    input  logic [BCD_W-1:0] i_d,
    output logic [BCD_W-1:0] o_d
);

    assign o_d = (i_d >= BCD_W'(5)) ? i_d + BCD_W'(3) : i_d;

endmodule

// File: rtl/score_digits.sv
// Serial binary-to-BCD score converter (one bit per cycle) with saturation
// and leading-zero blank flags for a seven-segment display.
module score_digits
    import score_pkg::*;
#(
    parameter int BIN_W      = 10,
    parameter int NUM_DIGITS = 3,
    parameter int BLANK_LZ   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BIN_W-1:0]              score_in,
    input  logic                          load,
    output logic                          busy,
    output logic                          valid,
    output logic [BCD_W*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]         blank,
    output logic                          overflow
);

    // Accumulator always spans the full BIN_W range so overflow is exact.
    localparam int ACC_D0 = dec_digits(BIN_W);
    localparam int ACC_D  = (ACC_D0 > NUM_DIGITS) ? ACC_D0 : NUM_DIGITS;
    localparam int ACC_W  = ACC_D * BCD_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [NUM_DIGITS-1:0] BLANK_RST =
        (BLANK_LZ != 0) ? ~NUM_DIGITS'(1) : '0;

    state_t                        r_state;
    logic [BIN_W-1:0]              r_sr;
    logic [ACC_W-1:0]              r_acc;
    logic [CNT_W-1:0]              r_cnt;
    logic [BCD_W*NUM_DIGITS-1:0]   r_digits;
    logic [NUM_DIGITS-1:0]         r_blank;
    logic                          r_ovf;

    logic [ACC_W-1:0]              w_adj;
    logic [ACC_W-1:0]              w_acc_nxt;
    logic [BCD_W*NUM_DIGITS-1:0]   w_dig;
    logic [NUM_DIGITS-1:0]         w_blank;
    logic                          w_ovf;
    logic                          w_lz;

    genvar g;
    generate
        for (g = 0; g < ACC_D; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_d (r_acc[g*BCD_W +: BCD_W]),
                .o_d (w_adj[g*BCD_W +: BCD_W])
            );
        end
    endgenerate

    assign w_acc_nxt = {w_adj[ACC_W-2:0], r_sr[BIN_W-1]};

    // Result as it will look after the final shift; only latched then.
    always_comb begin
        w_ovf = 1'b0;
        for (int i = NUM_DIGITS; i < ACC_D; i++) begin
            if (w_acc_nxt[i*BCD_W +: BCD_W] != '0) w_ovf = 1'b1;
        end
        w_dig = w_ovf ? {NUM_DIGITS{4'h9}} : w_acc_nxt[BCD_W*NUM_DIGITS-1:0];
        w_blank = '0;
        w_lz    = 1'b1;
        if (BLANK_LZ != 0) begin
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                w_lz       = w_lz & (w_dig[i*BCD_W +: BCD_W] == '0);
                w_blank[i] = w_lz;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sr     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_digits <= '0;
            r_blank  <= BLANK_RST;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_sr    <= score_in;
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(BIN_W);
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_nxt;
                    r_sr  <= r_sr << 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_digits <= w_dig;
                        r_blank  <= w_blank;
                        r_ovf    <= w_ovf;
                        r_state  <= S_COMMIT;
                    end
                end
                S_COMMIT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign valid    = (r_state == S_COMMIT);
    assign digits   = r_digits;
    assign blank    = r_blank;
    assign overflow = r_ovf;

endmodule
